teclado_rx: RTL and testbench
=============================

Name: teclado_rx

Overview:
- PS/2 keyboard (device-to-host) serial receiver.
- Samples the raw PS/2 clock and data lines in the system clock domain and de-glitches the PS/2 clock.
- Assembles each 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
- Presents the received scan-code byte with a one-cycle done strobe. Sits between the keyboard pins and the scan-code decoder.

Parameters:
- FILTER_LEN, 8: number of consecutive identical system-clock samples of ps2c required to change the filtered PS/2 clock level.
- TIMEOUT_CYC, 50000: system-clock cycles without a filtered ps2c falling edge, mid-frame, before the frame is abandonned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz nominal, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2d  input  1  raw PS/2 data line, asynchronous.
- ps2c  input  1  raw PS/2 clock line, asynchronous.
- rx_en  input  1  receive enable; a new frame may start only while high.
- rx_done_tick  output  1  one-cycle pulse: a valid byte is on dout.
- dout  output  8  last correctly received data byte.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; bit counter, shift register and timeout counter clear.
  - Filter history is all 1s and filtered clock = 1.
  - dout = 8'h00, rx_done_tick = 0.
- Input sync: ps2c and ps2d each pass through a 2-flop synchronizer before any use.
- Filter:
  - FILTER_LEN-bit shift register of synced ps2c.
  - Filtered clock goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds.
  - fall_edge is a one-cycle pulse when filtered clock goes 1 to 0.
  - Data is sampled (synced ps2d) in the same cycle fall_edge is high.
- FSM states IDLE, DPS, LOAD:
  - IDLE: if fall_edge and rx_en=1 and sampled ps2d=0 (start bit), go to DPS with bit counter = 10 and timeout counter cleared. Any other fall_edge is ignored.
  - DPS: on each fall_edge, shift the sampled ps2d into a 10-bit shift register from the MSB side (right shift) and decrement the counter. The fall_edge that brings the counter to 0 (the stop bit) moves to LOAD.
  - DPS timeout: without fall_edge, increment the timeout counter; when it reaches TIMEOUT_CYC, return to IDLE with no tick and dout unchanged.
  - LOAD: lasts exactly one cycle, then IDLE. Shift register holds {stop, parity, d7..d0}.
  - LOAD, frame valid (stop=1 and d7..d0 plus parity contain an odd number of 1s): dout <= d7..d0 and rx_done_tick = 1 for this cycle's output (registered, visible the cycle after LOAD is entered).
  - LOAD, frame invalid: no tick, dout held.
- dout holds its value between frames; it changes only on a valid frame.
- rx_done_tick is exactly one clk cycle wide and coincides with the new dout value.
- Latency: rx_done_tick asserts at most FILTER_LEN+5 clk cycles after the raw ps2c falling edge of the stop bit.
- rx_en is checked only in IDLE. Deasserting it mid-frame does not abort the frame.
- An asynchronous reset mid-frame aborts the frame immediately; the first frame after release is received normally.
- Glitches on ps2c shorter than FILTER_LEN cycles produce no fall_edge.
- Back-to-back frames separated by one ps2c high period are received without loss.

Test Plan:
- Send start 0, data LSB-first 0,1,0,1,1,0,1,0, parity 1, stop 1, with 10 kHz ps2c and data stable around falling edges -> one rx_done_tick, dout=8'h5A.
- Same frame with parity 0 -> no rx_done_tick, dout remains 8'h00 (or the previous byte).
- Frame for byte 8'hF0 (parity 1), then byte 8'h1C (parity 0) back-to-back -> two ticks, dout=8'hF0 then 8'h1C.
- rx_en=0 while sending the 8'h5A frame -> no tick, dout unchanged. Raise rx_en while ps2c idle high and resend -> tick with dout=8'h5A.
- 3-cycle low glitch on ps2c while idle, then a valid frame -> glitch ignored, single tick with the correct byte.
- Stop ps2c after 4 data bits for more than TIMEOUT_CYC cycles, then send a full 8'h5A frame -> no tick for the partial frame, tick with dout=8'h5A for the full one. Also assert reset mid-frame -> dout=8'h00, rx_done_tick=0 immediately.

Source files
------------

// File: rtl/teclado_rx.sv
// PS/2 keyboard device-to-host receiver: synchronizes and de-glitches ps2c,
// assembles 11-bit frames and strobes each correctly received scan-code byte.
module teclado_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned NW = 4;
  localparam int unsigned BW = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [NW-1:0]         n_reg, n_next;
  logic [BW-1:0]         b_reg, b_next;
  logic [TW-1:0]         t_reg, t_next;
  logic [7:0]            dout_next;
  logic                  tick_next;

  logic                  ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
  logic [FILTER_LEN-1:0] filt_reg, filt_next;
  logic                  fclk_reg, fclk_next;
  logic                  fall_edge_c;
  logic                  frame_ok_c;

  // Two-flop synchronizers; idle line level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_s1 <= 1'b1;
      ps2c_s2 <= 1'b1;
      ps2d_s1 <= 1'b1;
      ps2d_s2 <= 1'b1;
    end else begin
      ps2c_s1 <= ps2c;
      ps2c_s2 <= ps2c_s1;
      ps2d_s1 <= ps2d;
      ps2d_s2 <= ps2d_s1;
    end
  end

  // Filtered clock changes only after FILTER_LEN identical samples.
  always_comb begin
    filt_next = {ps2c_s2, filt_reg[FILTER_LEN-1:1]};
    fclk_next = fclk_reg;
    if (&filt_next) begin
      fclk_next = 1'b1;
    end else if (~|filt_next) begin
      fclk_next = 1'b0;
    end
  end

  assign fall_edge_c = fclk_reg & ~fclk_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_reg <= {FILTER_LEN{1'b1}};
      fclk_reg <= 1'b1;
    end else begin
      filt_reg <= filt_next;
      fclk_reg <= fclk_next;
    end
  end

  // Stop bit high and odd parity across data plus parity bit.
  assign frame_ok_c = b_reg[9] & (^b_reg[8:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      n_reg        <= '0;
      b_reg        <= '0;
      t_reg        <= '0;
      dout         <= 8'h00;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_next;
      n_reg        <= n_next;
      b_reg        <= b_next;
      t_reg        <= t_next;
      dout         <= dout_next;
      rx_done_tick <= tick_next;
    end
  end

  always_comb begin
    state_next = state;
    n_next     = n_reg;
    b_next     = b_reg;
    t_next     = t_reg;
    dout_next  = dout;
    tick_next  = 1'b0;
    case (state)
      IDLE: begin
        if (fall_edge_c && rx_en && !ps2d_s2) begin
          state_next = DPS;
          n_next     = NW'(10);
          t_next     = '0;
        end
      end
      DPS: begin
        if (fall_edge_c) begin
          b_next = {ps2d_s2, b_reg[BW-1:1]};
          n_next = n_reg - NW'(1);
          t_next = '0;
          if (n_reg == NW'(1)) begin
            state_next = LOAD;
          end
        end else if (t_reg == TW'(TIMEOUT_CYC - 1)) begin
          // Keyboard stopped clocking mid-frame: abandon it silently.
          state_next = IDLE;
          t_next     = '0;
        end else begin
          t_next = t_reg + TW'(1);
        end
      end
      LOAD: begin
        state_next = IDLE;
        if (frame_ok_c) begin
          dout_next = b_reg[7:0];
          tick_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_teclado_rx.sv
// Directed self-checking bench for teclado_rx with a shortened PS/2 clock
// period and timeout so that all scenarios fit in a short run.
module tb_teclado_rx;

  localparam int H       = 50;    // ps2c half period in clk cycles
  localparam int TIMEOUT = 1000;

  logic       clk;
  logic       reset;
  logic       ps2d;
  logic       ps2c;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  logic [7:0] tick_log [0:31];

  teclado_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .rx_en        (rx_en),
    .rx_done_tick (rx_done_tick),
    .dout         (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle the tick is high counts, so a two-cycle tick shows up as extra.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      if (tick_cnt < 32) tick_log[tick_cnt] = dout;
      tick_cnt = tick_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bit 0 is the start bit; sends the first nbits bits of it.
  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = frame[i];
      repeat (H) @(posedge clk);
      ps2c = 1'b0;
      repeat (H) @(posedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (H) @(posedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par);
    return {1'b1, par, d, 1'b0};
  endfunction

  int base;

  initial begin
    reset = 1'b0;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_tick", 32'(rx_done_tick), 32'h0);
    reset = 1'b1;
    repeat (20) @(posedge clk);

    // Valid 5A frame
    base = tick_cnt;
    send_bits(mk(8'h5A, 1'b1), 11);
    check("5a_ticks", 32'(tick_cnt - base), 32'd1);
    check("5a_byte", 32'(tick_log[base]), 32'h5A);
    check("5a_dout", 32'(dout), 32'h5A);

    // Parity error
    base = tick_cnt;
    send_bits(mk(8'h5A, 1'b0), 11);
    check("badpar_ticks", 32'(tick_cnt - base), 32'd0);
    check("badpar_dout", 32'(dout), 32'h5A);

    // Back-to-back F0 then 1C
    base = tick_cnt;
    send_bits(mk(8'hF0, 1'b1), 11);
    send_bits(mk(8'h1C, 1'b0), 11);
    check("b2b_ticks", 32'(tick_cnt - base), 32'd2);
    check("b2b_first", 32'(tick_log[base]), 32'hF0);
    check("b2b_second", 32'(tick_log[base+1]), 32'h1C);
    check("b2b_dout", 32'(dout), 32'h1C);

    // Receiver disabled
    rx_en = 1'b0;
    base = tick_cnt;
    send_bits(mk(8'h5A, 1'b1), 11);
    check("rxdis_ticks", 32'(tick_cnt - base), 32'd0);
    check("rxdis_dout", 32'(dout), 32'h1C);
    rx_en = 1'b1;
    repeat (10) @(posedge clk);
    base = tick_cnt;
    send_bits(mk(8'h5A, 1'b1), 11);
    check("rxen_ticks", 32'(tick_cnt - base), 32'd1);
    check("rxen_dout", 32'(dout), 32'h5A);

    // Short glitch on ps2c, then a valid 3C frame
    base = tick_cnt;
    ps2d = 1'b0;
    ps2c = 1'b0;
    repeat (3) @(posedge clk);
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (40) @(posedge clk);
    check("glitch_ticks", 32'(tick_cnt - base), 32'd0);
    send_bits(mk(8'h3C, 1'b1), 11);
    check("glitch_frame_ticks", 32'(tick_cnt - base), 32'd1);
    check("glitch_frame_dout", 32'(dout), 32'h3C);

    // Partial frame: start + 4 data bits, then silence past the timeout
    base = tick_cnt;
    send_bits(mk(8'h5A, 1'b1), 5);
    repeat (TIMEOUT + 500) @(posedge clk);
    check("timeout_ticks", 32'(tick_cnt - base), 32'd0);
    check("timeout_dout", 32'(dout), 32'h3C);
    send_bits(mk(8'h5A, 1'b1), 11);
    check("after_to_ticks", 32'(tick_cnt - base), 32'd1);
    check("after_to_dout", 32'(dout), 32'h5A);

    // Asynchronous reset in the middle of a frame
    send_bits(mk(8'hF0, 1'b1), 4);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_dout", 32'(dout), 32'h00);
    check("midrst_tick", 32'(rx_done_tick), 32'h0);
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (5) @(posedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    base = tick_cnt;
    send_bits(mk(8'h1C, 1'b0), 11);
    check("postrst_ticks", 32'(tick_cnt - base), 32'd1);
    check("postrst_dout", 32'(dout), 32'h1C);

    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
